sound_frame_seq: RTL and testbench
==================================

// Module: sound_frame_seq
// PURPOSE
//   APU frame sequencer and trigger scheduler for the tone/wave/noise channels. Divides the
//   CPU clock into 2097152 Hz divider enables and the 512 Hz 8-step frame sequence.
//   Emits length (256 Hz), sweep (128 Hz) and envelope (64 Hz) ticks.
//   Converts register-write trigger strobes into held start pulses per channel.
//   Sits between the sound register decode and the per-channel generators.
// PARAMETERS
//   NCH         4     number of channels served (start/trigger vector width)
//   DIV_512     8192  clk cycles per frame step (4194304 Hz / 512 Hz)
//   START_HOLD  4     clk cycles each start pulse is held high (1..15)
// PORTS
//   clk           in   1        CPU clock, 4194304 Hz
//   rst           in   1        synchronous reset, active-high
//   power_en      in   1        master sound enable (NR52 bit 7); 0 = APU off
//   trig_in       in   NCH      1-cycle strobe: write with trigger bit (NRx4 bit 7) set
//   tick_freq_div out  1        1-cycle enable every 2nd clk (2097152 Hz)
//   tick_length   out  1        1-cycle enable, frame steps 0,2,4,6
//   tick_sweep    out  1        1-cycle enable, frame steps 2,6
//   tick_env      out  1        1-cycle enable, frame step 7
//   start_out     out  NCH      per-channel start, held START_HOLD cycles
//   step          out  3        current frame step 0..7
// BEHAVIOUR
//   - Reset (rst=1 at a clk edge): div_cnt=0, step=0, fd_toggle=0, all ticks=0,
//     start_out=0, all hold counters=0. Reset mid-hold drops start_out the next cycle.
//   - tick_freq_div: fd_toggle flips each clk while power_en=1; tick_freq_div=fd_toggle
//     (registered, high every 2nd cycle, first high 1 cycle after power_en rises).
//   - div_cnt: 13-bit counter, increments each clk while power_en=1. At DIV_512-1 it
//     wraps to 0 and step advances mod 8 (7 -> 0).
//   - Ticks are registered and asserted in the cycle after the step advance.
//     Each is high for exactly 1 clk, decoded from the new step value:
//     step 0: length | 1: - | 2: length+sweep | 3: - | 4: length | 5: - |
//     step 6: length+sweep | 7: env.
//   - No tick at power-up: the first step advance occurs DIV_512 cycles after
//     power_en rises (step 0 -> 1, no tick).
//   - power_en=0: div_cnt, step and fd_toggle are forced to 0 each cycle; ticks are 0;
//     start_out is 0; hold counters are cleared; trig_in is ignored.
//     power_en rising restarts from step 0, div_cnt 0.
//   - Trigger (per channel i, independent): trig_in[i]=1 loads hold_cnt[i]=START_HOLD.
//     start_out[i] is registered high whenever hold_cnt[i]!=0; hold_cnt decrements to 0.
//     Latency trig_in -> start_out is 1 clk; the pulse width is exactly START_HOLD clks.
//   - Retrigger while holding reloads hold_cnt to START_HOLD (pulse is extended, no gap).
//   - Simultaneous triggers on several channels are all honoured in the same cycle.
//     A trigger coincident with a tick is not delayed or reordered.
//   - Arithmetic: all counters are unsigned. div_cnt compares against DIV_512-1 at
//     13-bit width; DIV_512 must be <= 8192.
// CONFIGURATION
//   SOUND_SEQ_FAST_EN defined: the divide constant is 16, not DIV_512 (for simulation of
//     full envelope/length runs). All other behaviour is identical.
//   SOUND_SEQ_FAST_EN undefined: DIV_512 is used as-is. Must be undefined for synthesis
//     builds.
// STRUCTURE
//   - Shared package sound_pkg: SEQ_STEP_* constants (0..7), step-to-tick mask constants
//     (LEN_MASK=8'b0101_0101, SWEEP_MASK=8'b0100_0100, ENV_MASK=8'b1000_0000),
//     DIV_512 default, START_HOLD default.
//   - Sub-module sound_trig_stretch: one hold counter plus start output. Instantiated
//     NCH times via generate. Ports: clk, rst, clr (=~power_en), trig, start.
// TESTING
//   1 rst=1 for 3 clk, then power_en=1 -> all outputs 0 during reset. tick_freq_div
//     toggles 0,1,0,1 from the cycle after power_en rises.
//   2 Run 8*DIV_512 clk (FAST: 128) -> exactly 4 tick_length, 2 tick_sweep and
//     1 tick_env pulses. tick_env follows step=7; step wraps 7 -> 0.
//   3 trig_in=4'b0101 for 1 clk -> start_out=4'b0101 from the next clk for exactly
//     4 clk, then 0.
//   4 trig_in[1] at t, again at t+2 -> start_out[1] high t+1..t+6 continuously
//     (6 clk), no gap.
//   5 power_en 1 -> 0 at step 5 while start_out[3] is high -> next clk step=0,
//     start_out=0, no ticks. power_en back to 1 -> first step advance after DIV_512 clk.
//   6 rst asserted for 1 clk mid-frame (step 3) with a hold active -> step=0,
//     start_out=0, no spurious tick on release.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants for the APU frame sequencer: step numbering, per-step tick masks,
// counter widths and parameter defaults.
package sound_pkg;

    localparam logic [2:0] SEQ_STEP_0 = 3'd0;
    localparam logic [2:0] SEQ_STEP_1 = 3'd1;
    localparam logic [2:0] SEQ_STEP_2 = 3'd2;
    localparam logic [2:0] SEQ_STEP_3 = 3'd3;
    localparam logic [2:0] SEQ_STEP_4 = 3'd4;
    localparam logic [2:0] SEQ_STEP_5 = 3'd5;
    localparam logic [2:0] SEQ_STEP_6 = 3'd6;
    localparam logic [2:0] SEQ_STEP_7 = 3'd7;

    // Bit n set means the tick fires when the sequencer arrives at step n.
    localparam logic [7:0] LEN_MASK   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_MASK = 8'b0100_0100;
    localparam logic [7:0] ENV_MASK   = 8'b1000_0000;

    localparam int DEF_DIV_512    = 8192;
    localparam int DEF_START_HOLD = 4;
    localparam int DIV_CNT_W      = 13;
    localparam int HOLD_CNT_W     = 4;

    typedef struct packed {
        logic length;
        logic sweep;
        logic env;
    } frame_ticks_t;

    function automatic frame_ticks_t step_ticks(input logic [2:0] s);
        frame_ticks_t t;
        t.length = LEN_MASK[s];
        t.sweep  = SWEEP_MASK[s];
        t.env    = ENV_MASK[s];
        return t;
    endfunction

endpackage

// File: rtl/sound_trig_stretch.sv
// Per-channel trigger stretcher: a trig strobe (re)loads the hold counter and the
// registered start output stays high while the counter is non-zero.
module sound_trig_stretch
    import sound_pkg::*;
#(
    parameter int START_HOLD = DEF_START_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic trig,
    output logic start
);

    logic [HOLD_CNT_W-1:0] hold_cnt_reg;
    logic [HOLD_CNT_W-1:0] hold_cnt_next;
    logic                  start_reg;

    // A retrigger simply reloads, so an active pulse is extended without a gap.
    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (clr) begin
            hold_cnt_next = '0;
        end else if (trig) begin
            hold_cnt_next = HOLD_CNT_W'(START_HOLD);
        end else if (hold_cnt_reg != '0) begin
            hold_cnt_next = hold_cnt_reg - HOLD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_reg <= '0;
            start_reg    <= 1'b0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
            start_reg    <= (hold_cnt_next != '0);
        end
    end

    assign start = start_reg;

endmodule

// File: rtl/sound_frame_seq.sv
// APU frame sequencer: 2097152 Hz divider enable, 512 Hz 8-step frame with length/sweep/
// envelope ticks, plus per-channel start stretchers. SOUND_SEQ_FAST_EN selects a divide of 16.
module sound_frame_seq
    import sound_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DIV_512    = DEF_DIV_512,
    parameter int START_HOLD = DEF_START_HOLD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           power_en,
    input  logic [NCH-1:0] trig_in,
    output logic           tick_freq_div,
    output logic           tick_length,
    output logic           tick_sweep,
    output logic           tick_env,
    output logic [NCH-1:0] start_out,
    output logic [2:0]     step
);

`ifdef SOUND_SEQ_FAST_EN
    localparam int DIV_EFF = 16;
`else
    localparam int DIV_EFF = DIV_512;
`endif
    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV_EFF - 1);

    logic [DIV_CNT_W-1:0] div_cnt_reg;
    logic [DIV_CNT_W-1:0] div_cnt_next;
    logic [2:0]           step_reg;
    logic [2:0]           step_next;
    logic                 fd_toggle_reg;
    logic                 fd_toggle_next;
    frame_ticks_t         ticks_reg;
    frame_ticks_t         ticks_next;
    logic                 clr;

    // With power off everything collapses to zero, so power-up always restarts at step 0.
    always_comb begin
        div_cnt_next   = '0;
        step_next      = SEQ_STEP_0;
        fd_toggle_next = 1'b0;
        ticks_next     = '0;
        if (power_en) begin
            fd_toggle_next = ~fd_toggle_reg;
            step_next      = step_reg;
            if (div_cnt_reg == DIV_LAST) begin
                step_next  = (step_reg == SEQ_STEP_7) ? SEQ_STEP_0 : step_reg + 3'd1;
                ticks_next = step_ticks(step_next);
            end else begin
                div_cnt_next = div_cnt_reg + DIV_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg   <= '0;
            step_reg      <= SEQ_STEP_0;
            fd_toggle_reg <= 1'b0;
            ticks_reg     <= '0;
        end else begin
            div_cnt_reg   <= div_cnt_next;
            step_reg      <= step_next;
            fd_toggle_reg <= fd_toggle_next;
            ticks_reg     <= ticks_next;
        end
    end

    assign tick_freq_div = fd_toggle_reg;
    assign tick_length   = ticks_reg.length;
    assign tick_sweep    = ticks_reg.sweep;
    assign tick_env      = ticks_reg.env;
    assign step          = step_reg;
    assign clr           = ~power_en;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            sound_trig_stretch #(
                .START_HOLD (START_HOLD)
            ) u_stretch (
                .clk   (clk),
                .rst   (rst),
                .clr   (clr),
                .trig  (trig_in[gi]),
                .start (start_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sound_frame_seq.sv
// Scoreboard bench for sound_frame_seq: expected per-cycle outputs are queued as stimulus
// is driven and compared once the clock edge has produced the DUT response.
module tb_sound_frame_seq;

    localparam int NCH    = 4;
    localparam int TB_DIV = 16;

    typedef struct packed {
        logic [2:0]     step;
        logic           fd;
        logic           len;
        logic           sw;
        logic           env;
        logic [NCH-1:0] start;
    } obs_t;

    logic           clk      = 1'b0;
    logic           rst      = 1'b1;
    logic           power_en = 1'b0;
    logic [NCH-1:0] trig_in  = '0;
    logic           tick_freq_div;
    logic           tick_length;
    logic           tick_sweep;
    logic           tick_env;
    logic [NCH-1:0] start_out;
    logic [2:0]     step;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   pwr_cyc  = 0;
    obs_t exp_q[$];

    sound_frame_seq #(
        .NCH        (NCH),
        .DIV_512    (TB_DIV),
        .START_HOLD (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .power_en      (power_en),
        .trig_in       (trig_in),
        .tick_freq_div (tick_freq_div),
        .tick_length   (tick_length),
        .tick_sweep    (tick_sweep),
        .tick_env      (tick_env),
        .start_out     (start_out),
        .step          (step)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    // Number of powered edges the sequencer will have seen after the coming edge.
    function automatic int pwr_after_edge();
        return (rst || !power_en) ? 0 : pwr_cyc + 1;
    endfunction

    // Frame outputs expected after pc powered edges since the last restart.
    function automatic obs_t frame_exp(input int pc, input logic [NCH-1:0] start);
        obs_t e;
        int   s;
        logic adv;
        s       = (pc / TB_DIV) % 8;
        adv     = (pc > 0) && (pc % TB_DIV == 0);
        e.step  = 3'(s);
        e.fd    = pc[0];
        e.len   = adv && (s % 2 == 0);
        e.sw    = adv && (s == 2 || s == 6);
        e.env   = adv && (s == 7);
        e.start = start;
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.step  = step;
        o.fd    = tick_freq_div;
        o.len   = tick_length;
        o.sw    = tick_sweep;
        o.env   = tick_env;
        o.start = start_out;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("step=%0d fd=%b len=%b sweep=%b env=%b start=%b",
                         o.step, o.fd, o.len, o.sw, o.env, o.start);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        pwr_cyc = (rst || !power_en) ? 0 : pwr_cyc + 1;
    endtask

    task automatic test_reset();
        obs_t got, e;
        rst = 1'b1; power_en = 1'b0; trig_in = '1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(frame_exp(pwr_after_edge(), '0));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL reset cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
        rst = 1'b0; power_en = 1'b1; trig_in = '0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(frame_exp(pwr_after_edge(), '0));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL fd_toggle cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_frame();
        obs_t got, e;
        int   n_len = 0, n_sw = 0, n_env = 0;
        logic wrap_seen = 1'b0;
        logic [2:0] prev_step = step;
        for (int i = 0; i < 8 * TB_DIV; i++) begin
            exp_q.push_back(frame_exp(pwr_after_edge(), '0));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL frame cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
            n_len += int'(got.len);
            n_sw  += int'(got.sw);
            n_env += int'(got.env);
            if (prev_step == 3'd7 && got.step == 3'd0) wrap_seen = 1'b1;
            prev_step = got.step;
        end
        n_checks++;
        if (n_len != 4 || n_sw != 2 || n_env != 1)
            $display("FAIL frame_counts: got len=%0d sweep=%0d env=%0d, want len=4 sweep=2 env=1",
                     n_len, n_sw, n_env);
        else n_pass++;
        n_checks++;
        if (wrap_seen !== 1'b1) $display("FAIL step_wrap: got wrap=%b, want 1", wrap_seen);
        else n_pass++;
    endtask

    task automatic test_trig_pulse();
        obs_t got, e;
        for (int i = 0; i < 6; i++) begin
            trig_in = (i == 0) ? 4'b0101 : 4'b0000;
            exp_q.push_back(frame_exp(pwr_after_edge(), (i < 4) ? 4'b0101 : 4'b0000));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL trig_pulse cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
        trig_in = '0;
    endtask

    task automatic test_retrigger();
        obs_t got, e;
        for (int i = 0; i < 8; i++) begin
            trig_in = (i == 0 || i == 2) ? 4'b0010 : 4'b0000;
            exp_q.push_back(frame_exp(pwr_after_edge(), (i < 6) ? 4'b0010 : 4'b0000));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL retrigger cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
        trig_in = '0;
    endtask

    task automatic test_back_to_back();
        obs_t got, e;
        logic [NCH-1:0] stag_trig [7] = '{4'b0001, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [NCH-1:0] stag_exp  [7] = '{4'b0001, 4'b0011, 4'b1011, 4'b1011, 4'b1010, 4'b1000, 4'b0000};
        // Line up so the all-channel trigger lands on the same edge as a step advance.
        for (int k = 0; k < TB_DIV && (pwr_after_edge() % TB_DIV != 0); k++) begin
            exp_q.push_back(frame_exp(pwr_after_edge(), '0));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL align cyc %0d: got %s, want %s", k, fmt(got), fmt(e));
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            trig_in = (i == 0) ? 4'b1111 : 4'b0000;
            exp_q.push_back(frame_exp(pwr_after_edge(), (i < 4) ? 4'b1111 : 4'b0000));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL trig_on_tick cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
        for (int i = 0; i < 7; i++) begin
            trig_in = stag_trig[i];
            exp_q.push_back(frame_exp(pwr_after_edge(), stag_exp[i]));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL staggered cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
        trig_in = '0;
    endtask

    task automatic test_power_off();
        obs_t got, e;
        for (int k = 0; k < 8 * TB_DIV && frame_exp(pwr_after_edge(), '0).step != 3'd5; k++) begin
            exp_q.push_back(frame_exp(pwr_after_edge(), '0));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL seek_step5 cyc %0d: got %s, want %s", k, fmt(got), fmt(e));
            else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            trig_in = (i == 0) ? 4'b1000 : 4'b0000;
            exp_q.push_back(frame_exp(pwr_after_edge(), 4'b1000));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL hold_ch3 cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
        power_en = 1'b0; trig_in = '1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(frame_exp(pwr_after_edge(), '0));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL power_off cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
        power_en = 1'b1; trig_in = '0;
        for (int i = 0; i < TB_DIV + 2; i++) begin
            exp_q.push_back(frame_exp(pwr_after_edge(), '0));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL power_restart cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, e;
        for (int k = 0; k < 8 * TB_DIV && frame_exp(pwr_after_edge(), '0).step != 3'd3; k++) begin
            exp_q.push_back(frame_exp(pwr_after_edge(), '0));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL seek_step3 cyc %0d: got %s, want %s", k, fmt(got), fmt(e));
            else n_pass++;
        end
        trig_in = 4'b0001;
        exp_q.push_back(frame_exp(pwr_after_edge(), 4'b0001));
        cyc();
        got = observe(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) $display("FAIL pre_reset_hold: got %s, want %s", fmt(got), fmt(e));
        else n_pass++;
        trig_in = '0; rst = 1'b1;
        exp_q.push_back(frame_exp(pwr_after_edge(), '0));
        cyc();
        got = observe(); e = exp_q.pop_front(); n_checks++;
        if (got !== e) $display("FAIL mid_reset: got %s, want %s", fmt(got), fmt(e));
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < TB_DIV + 2; i++) begin
            exp_q.push_back(frame_exp(pwr_after_edge(), '0));
            cyc();
            got = observe(); e = exp_q.pop_front(); n_checks++;
            if (got !== e) $display("FAIL reset_release cyc %0d: got %s, want %s", i, fmt(got), fmt(e));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_trig_pulse();
        test_retrigger();
        test_back_to_back();
        test_power_off();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
